// File: rtl/bp_be_ckpt_queue.sv
// Checkpointed queue: read pointer runs ahead speculatively, commit advances the
// checkpoint, roll rewinds reads to it. Optional same-cycle bypass via BP_BE_CKPT_QUEUE_BYPASS_EN.
module bp_be_ckpt_queue #(
    parameter int unsigned width_p   = 32,
    parameter int unsigned els_p     = 8,
    parameter int unsigned deq_max_p = 2,
    localparam int unsigned aw       = $clog2(els_p),
    localparam int unsigned pw       = aw + 1,
    localparam int unsigned cw       = $clog2(els_p + 1),
    localparam int unsigned dw       = $clog2(deq_max_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic [dw-1:0]      deq_cnt_i,
    input  logic               roll_i,
    input  logic               clr_i,
    input  logic               suppress_i,
    output logic [cw-1:0]      count_o,
    output logic [cw-1:0]      spec_cnt_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [pw-1:0]      wptr_q, wptr_d;
    logic [pw-1:0]      rptr_q, rptr_d;
    logic [pw-1:0]      cptr_q, cptr_d;
    logic [pw-1:0]      occ, spec;
    logic               full, empty, enq, deq;

    // Status, handshakes and next-pointer computation
    always_comb begin
        occ         = wptr_q - cptr_q;
        spec        = rptr_q - cptr_q;
        full        = (occ == pw'(els_p));
        empty       = (rptr_q == wptr_q);
        ready_and_o = ~full & ~suppress_i & ~clr_i;
        enq         = v_i & ready_and_o;
        v_o         = ~empty & ~suppress_i & ~clr_i & ~roll_i;
        data_o      = mem_q[rptr_q[aw-1:0]];
`ifdef BP_BE_CKPT_QUEUE_BYPASS_EN
        if (empty && enq && !roll_i) begin
            v_o    = 1'b1;
            data_o = data_i;
        end
`endif
        deq        = yumi_i & v_o;
        count_o    = cw'(occ);
        spec_cnt_o = cw'(spec);

        wptr_d = wptr_q + pw'(enq);
        cptr_d = cptr_q + pw'(deq_cnt_i);
        rptr_d = roll_i ? cptr_d : (rptr_q + pw'(deq));
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q[aw-1:0]] <= data_i;
    end

    // Commits may only retire entries that have already been read
    assert property (@(posedge clk_i) disable iff (reset_i) (cw'(deq_cnt_i) <= spec_cnt_o))
        else $error("deq_cnt_i exceeds spec_cnt_o");

endmodule
